// File: rtl/bsg_gateway_io_cmd_arbiter_if.sv
// Bundle of the requester, host-link and status signals of the gateway I/O command arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface bsg_gateway_io_cmd_arbiter_if #(
  parameter int unsigned msg_width_p       = 128,
  parameter int unsigned max_outstanding_p = 4
) ();

  localparam int unsigned cnt_width_lp = $clog2(max_outstanding_p + 1);

  // Requester side; requester r owns slice r
  logic [1:0][msg_width_p-1:0] cmd_i;
  logic [1:0]                  cmd_v_i;
  logic [1:0]                  cmd_ready_o;
  logic [msg_width_p-1:0]      resp_o;
  logic [1:0]                  resp_v_o;
  logic [1:0]                  resp_yumi_i;

  // Host link side
  logic [msg_width_p-1:0]      io_cmd_o;
  logic                        io_cmd_v_o;
  logic                        io_cmd_ready_i;
  logic [msg_width_p-1:0]      io_resp_i;
  logic                        io_resp_v_i;
  logic                        io_resp_ready_o;

  // Status
  logic [cnt_width_lp-1:0]     outstanding_o;
  logic                        error_o;

  modport slave (
    input  cmd_i, cmd_v_i, resp_yumi_i, io_cmd_ready_i, io_resp_i, io_resp_v_i,
    output cmd_ready_o, resp_o, resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o,
           outstanding_o, error_o
  );

  modport master (
    output cmd_i, cmd_v_i, resp_yumi_i, io_cmd_ready_i, io_resp_i, io_resp_v_i,
    input  cmd_ready_o, resp_o, resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o,
           outstanding_o, error_o
  );

endinterface

// File: rtl/bsg_gateway_io_cmd_arbiter.sv
// Round-robin arbiter sharing the host I/O command channel between two BedRock requesters.
// Issued requester IDs are tracked in order so responses are steered back to their owner.
module bsg_gateway_io_cmd_arbiter #(
  parameter int unsigned msg_width_p       = 128,
  parameter int unsigned max_outstanding_p = 4
) (
  input logic                              blackparrot_clk,
  input logic                              blackparrot_reset,
  bsg_gateway_io_cmd_arbiter_if.slave      bus
);

  localparam int unsigned ptr_width_lp = $clog2(max_outstanding_p);
  localparam int unsigned cnt_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_outstanding_p);

  // Output stage
  logic                         buf_v_q, buf_v_d;
  logic [msg_width_p-1:0]       buf_msg_q, buf_msg_d;
  // Requester favoured when both are valid
  logic                         prio_q, prio_d;
  // In-order tracking FIFO of requester IDs; occupancy equals the outstanding count
  logic [max_outstanding_p-1:0] id_mem_q, id_mem_d;
  logic [ptr_width_lp-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ptr_width_lp-1:0]      wr_ptr_q, wr_ptr_d;
  logic [cnt_width_lp-1:0]      cnt_q, cnt_d;
  logic                         error_q, error_d;

  logic can_accept;
  logic winner;
  logic accept;
  logic empty;
  logic head;
  logic pop;

  // Grant: single valid requester wins, otherwise the favoured one; ready only to the winner
  always_comb begin
    can_accept      = (~buf_v_q | bus.io_cmd_ready_i) & (cnt_q < max_cnt_lp);
    winner          = (&bus.cmd_v_i) ? prio_q : bus.cmd_v_i[1];
    accept          = can_accept & (|bus.cmd_v_i);
    bus.cmd_ready_o = '0;
    bus.cmd_ready_o[winner] = accept;
  end

  // Response steering to the requester at the head of the tracking FIFO
  always_comb begin
    empty               = (cnt_q == '0);
    head                = id_mem_q[rd_ptr_q];
    pop                 = ~empty & bus.resp_yumi_i[head];
    bus.resp_o          = bus.io_resp_i;
    bus.resp_v_o        = '0;
    bus.resp_v_o[head]  = bus.io_resp_v_i & ~empty;
    // Stray responses are sunk so the link never stalls on them
    bus.io_resp_ready_o = empty | bus.resp_yumi_i[head];
  end

  // Registered outputs toward the host link and status
  always_comb begin
    bus.io_cmd_o      = buf_msg_q;
    bus.io_cmd_v_o    = buf_v_q;
    bus.outstanding_o = cnt_q;
    bus.error_o       = error_q;
  end

  // Next-state: load buffer on accept, drain on transfer, push/pop tracking FIFO
  always_comb begin
    buf_v_d   = buf_v_q;
    buf_msg_d = buf_msg_q;
    prio_d    = prio_q;
    id_mem_d  = id_mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    error_d   = error_q;

    if (accept) begin
      buf_msg_d          = bus.cmd_i[winner];
      buf_v_d            = 1'b1;
      prio_d             = ~winner;
      id_mem_d[wr_ptr_q] = winner;
      wr_ptr_d           = wr_ptr_q + ptr_width_lp'(1);
    end else if (buf_v_q & bus.io_cmd_ready_i) begin
      buf_v_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
    end

    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + cnt_width_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_width_lp'(1);
      default: cnt_d = cnt_q;
    endcase

    if (bus.io_resp_v_i & empty) begin
      error_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      buf_v_q   <= 1'b0;
      buf_msg_q <= '0;
      prio_q    <= 1'b0;
      id_mem_q  <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      buf_v_q   <= buf_v_d;
      buf_msg_q <= buf_msg_d;
      prio_q    <= prio_d;
      id_mem_q  <= id_mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: doc/bsg_gateway_io_cmd_arbiter.md
# bsg_gateway_io_cmd_arbiter

Shares the single host-side I/O command channel of the gateway testbench between two BedRock memory-message requesters: port 0 is the NBF loader, port 1 is a secondary host master such as a debug or trace poker. Commands are arbitrated round-robin into a one-entry registered output stage. The requester ID of every issued command is recorded in an in-order tracking FIFO, and responses returning from the host link are steered back to the correct requester. The block sits between the requesters and the bidirectional host link's command-in / response-out ports.

## Interface
- msg_width_p, 128, width of a packed BedRock cce mem message (header plus data)
- max_outstanding_p, 4, maximum commands issued but not yet answered; power of two, ≥2
- blackparrot_clk  in  1  clock
- blackparrot_reset  in  1  reset, asynchronous, active-low
- cmd_i  in  2×msg_width_p  per-requester command; requester r uses slice r
- cmd_v_i  in  2  per-requester command valid
- cmd_ready_o  out  2  per-requester command ready; transfer when v & ready
- resp_o  out  msg_width_p  response payload, broadcast to both requesters
- resp_v_o  out  2  per-requester response valid
- resp_yumi_i  in  2  per-requester response consume; legal only while matching resp_v_o is high
- io_cmd_o  out  msg_width_p  command to the host link
- io_cmd_v_o  out  1  command valid
- io_cmd_ready_i  in  1  link ready; transfer when v & ready
- io_resp_i  in  msg_width_p  response from the host link
- io_resp_v_i  in  1  response valid
- io_resp_ready_o  out  1  response ready
- outstanding_o  out  clog2(max_outstanding_p+1)  count of commands issued but not yet answered
- error_o  out  1  sticky; set when a response arrives with no tracked command

## Operation
- State:
  - output buffer (buf_v, buf_msg)
  - round-robin priority bit prio (the requester favoured on conflict)
  - tracking FIFO of 1-bit requester IDs, depth max_outstanding_p
  - counter outstanding_o
  - error flag
- Accept condition: can_accept = (~buf_v | io_cmd_ready_i) & (outstanding_o < max_outstanding_p). There is no bypass from a same-cycle response pop.
- Grant:
  - If only one requester is valid, it wins.
  - If both are valid, requester prio wins.
  - cmd_ready_o[r] = can_accept & (winner == r). At most one ready bit is high per cycle.
- On command accept from requester r:
  - buf_msg ← cmd_i[r]; buf_v ← 1
  - push r into the FIFO; outstanding_o increments
  - prio ← ~r
- On downstream drain (io_cmd_v_o & io_cmd_ready_i) with no same-cycle accept: buf_v ← 0.
- io_cmd_o = buf_msg; io_cmd_v_o = buf_v. Once raised, io_cmd_v_o and io_cmd_o are held stable until the transfer.
- Response routing, with head = FIFO head ID and empty = FIFO empty:
  - resp_o = io_resp_i
  - resp_v_o[head] = io_resp_v_i & ~empty; the other resp_v_o bit is 0
  - io_resp_ready_o = empty ? 1 : resp_yumi_i[head]
  - On resp_yumi_i[head]: pop the FIFO; outstanding_o decrements
- Unexpected response (io_resp_v_i & empty): sink it (ready=1), set error_o, hold the counter at 0.
- Simultaneous accept and response pop: the counter is unchanged; push and pop both occur.
- Responses must return in command order. The block does not reorder.

## Timing
- Reset (blackparrot_reset low, asynchronous): buf_v=0, io_cmd_v_o=0, outstanding_o=0, FIFO empty, prio=0, error_o=0, cmd_ready_o=0, resp_v_o=0.
  - io_resp_ready_o=1 during reset because the FIFO is empty.
  - Reset mid-operation discards the buffered command and all tracking state.
- Command latency: accepted at edge N, io_cmd_v_o high from cycle N+1.
- Throughput: 1 command/cycle while io_cmd_ready_i stays high and credits remain.
- Response path is combinational: io_resp_v_i → resp_v_o, and resp_yumi_i → io_resp_ready_o, within the same cycle. The FIFO pops at the consuming edge.
- There is no combinational path from cmd_v_i to io_cmd_v_o, or from io_resp_v_i to cmd_ready_o.

## Test plan
- Both requesters hold valid for 6 commands each, io_cmd_ready_i=1, responses returned after 3 cycles. Required:
  - grants alternate 0,1,0,1,…
  - io_cmd_o order matches
  - each response reaches only the issuing requester's resp_v_o
- Requester 0 alone issues 5 commands with no responses, max_outstanding_p=4. Required:
  - outstanding_o reaches 4
  - cmd_ready_o[0] drops while the 5th command waits
  - one response is consumed → ready returns the next cycle, and the 5th command issues
- io_cmd_ready_i held low for 10 cycles with a command buffered. Required:
  - io_cmd_o and io_cmd_v_o stay constant
  - cmd_ready_o=0 for both requesters
  - on release, the transfer completes and the next accept occurs the same cycle
- Response injected with the FIFO empty. Required:
  - io_resp_ready_o=1
  - resp_v_o=00
  - error_o rises the next cycle and stays high
  - outstanding_o stays 0
- Same-cycle command accept and response yumi at outstanding_o=2. Required: outstanding_o remains 2, and FIFO order is preserved.
- Reset asserted with 3 outstanding commands and buf_v=1. Required:
  - all outputs return to their reset values immediately
  - after release, requester 0 wins the first conflict
